// File: rtl/atm_pkg.sv
// Shared types and constants for the ATM login/session controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package atm_pkg;

    localparam int PASS_W = 4;
    localparam int ID_W   = 4;

    localparam logic ON  = 1'b1;
    localparam logic OFF = 1'b0;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_WAIT_PASS = 3'd1,
        ST_SUBMIT    = 3'd2,
        ST_CHECK     = 3'd3,
        ST_SESSION   = 3'd4,
        ST_LOCKED    = 3'd5,
        ST_EJECT     = 3'd6
    } state_t;

endpackage

// File: rtl/atm_down_counter.sv
// Loadable down-counter that saturates at zero and flags when it is there.
// Latency: load and decrement take effect on the next clock edge; zero is combinational from the count.
// Backpressure: none; load has priority over decrement every cycle.
module atm_down_counter #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic             zero
);

    logic [WIDTH-1:0] count;

    // Load on request, otherwise count down and hold at zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/atm_session_controller.sv
// Card/password login sequencer in front of the password checker, with retry lockout and session idle timeout.
// Latency: PassValid -> SUBMIT +1, CHECK +2, verdict (AuthFail or SessionActive) visible at +3.
// Backpressure: none; strobes arriving outside the state that consumes them are dropped, never queued.
module atm_session_controller
    import atm_pkg::*;
#(
    parameter int MAX_TRIES   = 3,
    parameter int LOCK_CYCLES = 1000,
    parameter int IDLE_CYCLES = 5000
) (
    input  logic              Clock,
    input  logic              ResetN,
    input  logic              CardIn,
    input  logic [PASS_W-1:0] PassIn,
    input  logic              PassValid,
    input  logic              Logout,
    input  logic              ActivityIn,
    output logic [PASS_W-1:0] CheckPassword,
    output logic              CheckSubmit,
    input  logic              CheckAuthorized,
    input  logic [ID_W-1:0]   CheckID,
    output logic              SessionActive,
    output logic [ID_W-1:0]   SessionID,
    output logic              AuthFail,
    output logic              Locked,
    output logic              EjectCard,
    output logic              Busy
);

    localparam int TRY_W  = $clog2(MAX_TRIES + 1);
    localparam int IDLE_W = $clog2(IDLE_CYCLES + 1);
    localparam int LOCK_W = $clog2(LOCK_CYCLES + 1);

    localparam logic [TRY_W-1:0]  TRY_MAX   = TRY_W'(MAX_TRIES);
    localparam logic [IDLE_W-1:0] IDLE_LOAD = IDLE_W'(IDLE_CYCLES - 1);
    localparam logic [LOCK_W-1:0] LOCK_LOAD = LOCK_W'(LOCK_CYCLES - 1);

    state_t            state;
    state_t            next_state;
    logic              card_prev;
    logic              card_rise;
    logic [TRY_W-1:0]  tries;
    logic [TRY_W-1:0]  tries_nxt;
    logic [TRY_W-1:0]  tries_inc;
    logic              idle_load;
    logic              idle_zero;
    logic              lock_load;
    logic              lock_zero;
    logic              capture_pw;
    logic              capture_id;
    logic              auth_fail_nxt;
    logic [PASS_W-1:0] check_password;
    logic [ID_W-1:0]   session_id;
    logic              auth_fail_q;

    assign card_rise = CardIn & ~card_prev;
    assign tries_inc = (tries == TRY_MAX) ? TRY_MAX : tries + 1'b1;

    atm_down_counter #(.WIDTH(IDLE_W)) u_idle_timer (
        .clk      (Clock),
        .rst_n    (ResetN),
        .load     (idle_load),
        .load_val (IDLE_LOAD),
        .zero     (idle_zero)
    );

    atm_down_counter #(.WIDTH(LOCK_W)) u_lock_timer (
        .clk      (Clock),
        .rst_n    (ResetN),
        .load     (lock_load),
        .load_val (LOCK_LOAD),
        .zero     (lock_zero)
    );

    // State register plus the card level history used for insert detection.
    always_ff @(posedge Clock or negedge ResetN) begin
        if (!ResetN) begin
            state     <= ST_IDLE;
            card_prev <= OFF;
        end else begin
            state     <= next_state;
            card_prev <= CardIn;
        end
    end

    // Next-state, timer loads and datapath capture enables; expiry only counts when no reload is pending.
    always_comb begin
        next_state    = state;
        tries_nxt     = tries;
        idle_load     = OFF;
        lock_load     = OFF;
        capture_pw    = OFF;
        capture_id    = OFF;
        auth_fail_nxt = OFF;
        case (state)
            ST_IDLE: begin
                if (card_rise) begin
                    next_state = ST_WAIT_PASS;
                    tries_nxt  = '0;
                    idle_load  = ON;
                end
            end
            ST_WAIT_PASS: begin
                if (!CardIn) begin
                    next_state = ST_IDLE;
                end else if (PassValid) begin
                    next_state = ST_SUBMIT;
                    capture_pw = ON;
                    idle_load  = ON;
                end else if (idle_zero) begin
                    next_state = ST_EJECT;
                end
            end
            ST_SUBMIT: begin
                next_state = ST_CHECK;
            end
            ST_CHECK: begin
                if (CheckAuthorized) begin
                    next_state = ST_SESSION;
                    capture_id = ON;
                    tries_nxt  = '0;
                    idle_load  = ON;
                end else begin
                    auth_fail_nxt = ON;
                    tries_nxt     = tries_inc;
                    if (tries_inc == TRY_MAX) begin
                        next_state = ST_LOCKED;
                        lock_load  = ON;
                    end else begin
                        next_state = ST_WAIT_PASS;
                        idle_load  = ON;
                    end
                end
            end
            ST_SESSION: begin
                if (!CardIn) begin
                    next_state = ST_IDLE;
                end else if (Logout) begin
                    next_state = ST_EJECT;
                end else if (ActivityIn) begin
                    idle_load = ON;
                end else if (idle_zero) begin
                    next_state = ST_EJECT;
                end
            end
            ST_LOCKED: begin
                if (lock_zero) begin
                    next_state = ST_EJECT;
                end
            end
            ST_EJECT: begin
                next_state = ST_IDLE;
            end
            default: begin
                next_state = ST_IDLE;
            end
        endcase
    end

    // Failed-attempt counter, password/ID capture and the registered reject pulse.
    always_ff @(posedge Clock or negedge ResetN) begin
        if (!ResetN) begin
            tries          <= '0;
            check_password <= '0;
            session_id     <= '0;
            auth_fail_q    <= OFF;
        end else begin
            tries       <= tries_nxt;
            auth_fail_q <= auth_fail_nxt;
            if (capture_pw) begin
                check_password <= PassIn;
            end
            if (capture_id) begin
                session_id <= CheckID;
            end
        end
    end

    assign CheckPassword = check_password;
    assign SessionID     = session_id;
    assign AuthFail      = auth_fail_q;
    assign CheckSubmit   = (state == ST_SUBMIT) || (state == ST_CHECK);
    assign Busy          = (state == ST_SUBMIT) || (state == ST_CHECK);
    assign SessionActive = (state == ST_SESSION);
    assign Locked        = (state == ST_LOCKED);
    assign EjectCard     = (state == ST_EJECT);

endmodule
